// File: rtl/rf_scoreboard.sv
// Issue-side hazard controller for a pipelined register file: tracks pending
// writes, stalls on RAW/WAW/capacity, and drains outstanding writes before halting.
module rf_scoreboard #(
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int MAXOUT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_vld,
  input  logic [AW-1:0]   iss_src0,
  input  logic            iss_use0,
  input  logic [AW-1:0]   iss_src1,
  input  logic            iss_use1,
  input  logic [AW-1:0]   iss_dst,
  input  logic            iss_we,
  output logic            iss_rdy,
  output logic            re0,
  output logic            re1,
  input  logic            wb_vld,
  input  logic [AW-1:0]   wb_addr,
  input  logic            hlt_req,
  output logic            hlt,
  output logic [NREG-1:0] pend,
  output logic [AW:0]     pend_cnt,
  output logic            err
);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t          state_q;
  logic [NREG-1:0] pend_q, pend_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            hlt_q;

  logic            clr, clr_ok, set, raw, waw, full;
  logic [NREG-1:0] clr_vec, set_vec, eff_pend;
  logic [AW:0]     cnt_after_clr;

  // A retiring write is invisible to this cycle's hazard check (RF writes before it reads).
  assign clr      = wb_vld & (wb_addr != '0);
  assign clr_vec  = clr ? (NREG'(1) << wb_addr) : '0;
  assign clr_ok   = clr & pend_q[wb_addr];
  assign eff_pend = pend_q & ~clr_vec;

  assign raw = (iss_use0 & (iss_src0 != '0) & eff_pend[iss_src0]) |
               (iss_use1 & (iss_src1 != '0) & eff_pend[iss_src1]);
  assign waw = iss_we & (iss_dst != '0) & eff_pend[iss_dst];

  // Only a real retirement frees a slot; a bogus writeback leaves the count alone.
  assign cnt_after_clr = cnt_q - (AW+1)'(clr_ok);
  assign full          = iss_we & (iss_dst != '0) & (cnt_after_clr == (AW+1)'(MAXOUT));

  assign iss_rdy = iss_vld & (state_q == RUN) & ~hlt_req & ~raw & ~waw & ~full;
  assign re0     = iss_rdy & iss_use0;
  assign re1     = iss_rdy & iss_use1;

  assign set     = iss_rdy & iss_we & (iss_dst != '0);
  assign set_vec = set ? (NREG'(1) << iss_dst) : '0;

  assign pend_d = (pend_q | set_vec) & ~clr_vec;
  assign cnt_d  = cnt_q + (AW+1)'(set) - (AW+1)'(clr_ok);
  assign err_d  = err_q | (wb_vld & ((wb_addr == '0) | ~pend_q[wb_addr]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pend_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      case (state_q)
        RUN: begin
          if (hlt_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if ((cnt_q == '0) || ((cnt_q == (AW+1)'(1)) && clr_ok)) begin
            state_q <= HALT;
            hlt_q   <= 1'b1;
          end
        end
        HALT: begin
          hlt_q <= 1'b1;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign hlt      = hlt_q;
  assign pend     = pend_q;
  assign pend_cnt = cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed, table-driven bench for rf_scoreboard: each row is one clock cycle of
// stimulus with its combinational handshake and post-edge register state.
module tb_rf_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_vld, iss_use0, iss_use1, iss_we;
  logic [3:0]  iss_src0, iss_src1, iss_dst;
  logic        iss_rdy, re0, re1;
  logic        wb_vld;
  logic [3:0]  wb_addr;
  logic        hlt_req, hlt, err;
  logic [15:0] pend;
  logic [4:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_scoreboard #(.NREG(16), .AW(4), .MAXOUT(4)) dut (
    .clk(clk), .rst(rst),
    .iss_vld(iss_vld), .iss_src0(iss_src0), .iss_use0(iss_use0),
    .iss_src1(iss_src1), .iss_use1(iss_use1), .iss_dst(iss_dst), .iss_we(iss_we),
    .iss_rdy(iss_rdy), .re0(re0), .re1(re1),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .hlt_req(hlt_req), .hlt(hlt),
    .pend(pend), .pend_cnt(pend_cnt), .err(err)
  );

  typedef struct {
    logic        vld;
    logic [3:0]  s0;
    logic        u0;
    logic [3:0]  s1;
    logic        u1;
    logic [3:0]  dst;
    logic        we;
    logic        wbv;
    logic [3:0]  wba;
    logic        hreq;
    logic        e_rdy;
    logic        e_re0;
    logic        e_re1;
    logic [15:0] e_pend;
    logic [4:0]  e_cnt;
    logic        e_err;
    logic        e_hlt;
  } vec_t;

  vec_t main_tbl[$];
  vec_t halt_tbl[$];

  function automatic vec_t mk(input int vld, input int s0, input int u0, input int s1,
                              input int u1, input int dst, input int we, input int wbv,
                              input int wba, input int hreq, input int rdy, input int r0,
                              input int r1, input int p, input int c, input int e,
                              input int h);
    vec_t v;
    v.vld = 1'(vld); v.s0 = 4'(s0); v.u0 = 1'(u0); v.s1 = 4'(s1); v.u1 = 1'(u1);
    v.dst = 4'(dst); v.we = 1'(we); v.wbv = 1'(wbv); v.wba = 4'(wba); v.hreq = 1'(hreq);
    v.e_rdy = 1'(rdy); v.e_re0 = 1'(r0); v.e_re1 = 1'(r1);
    v.e_pend = 16'(p); v.e_cnt = 5'(c); v.e_err = 1'(e); v.e_hlt = 1'(h);
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    iss_vld = 0; iss_src0 = 0; iss_use0 = 0; iss_src1 = 0; iss_use1 = 0;
    iss_dst = 0; iss_we = 0; wb_vld = 0; wb_addr = 0; hlt_req = 0;
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic do_row(input vec_t v, input string tag, input int idx);
    iss_vld = v.vld; iss_src0 = v.s0; iss_use0 = v.u0; iss_src1 = v.s1;
    iss_use1 = v.u1; iss_dst = v.dst; iss_we = v.we; wb_vld = v.wbv;
    wb_addr = v.wba; hlt_req = v.hreq;
    #2;
    chk({tag, ".iss_rdy"}, idx, iss_rdy, v.e_rdy);
    chk({tag, ".re0"}, idx, re0, v.e_re0);
    chk({tag, ".re1"}, idx, re1, v.e_re1);
    @(posedge clk);
    #1;
    chk({tag, ".pend"}, idx, pend, v.e_pend);
    chk({tag, ".pend_cnt"}, idx, pend_cnt, v.e_cnt);
    chk({tag, ".err"}, idx, err, v.e_err);
    chk({tag, ".hlt"}, idx, hlt, v.e_hlt);
    $display("row %s[%0d]: rdy=%0b re0=%0b re1=%0b pend=%04h cnt=%0d err=%0b hlt=%0b",
             tag, idx, v.e_rdy, v.e_re0, v.e_re1, pend, pend_cnt, err, hlt);
  endtask

  task automatic apply_reset(input string tag);
    drive_idle();
    rst = 1'b1;
    #1;
    chk({tag, ".hlt"}, 0, hlt, 0);
    chk({tag, ".pend"}, 0, pend, 0);
    chk({tag, ".pend_cnt"}, 0, pend_cnt, 0);
    chk({tag, ".err"}, 0, err, 0);
    chk({tag, ".iss_rdy"}, 0, iss_rdy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset %s: pend=%04h cnt=%0d err=%0b hlt=%0b", tag, pend, pend_cnt, err, hlt);
  endtask

  initial begin
    //                vld s0 u0 s1 u1 dst we wbv wba hr  rdy r0 r1  pend    cnt err hlt
    main_tbl.push_back(mk(1, 3, 1, 0, 0, 5, 1, 0, 0, 0,  1, 1, 0, 16'h0020, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0020, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0020, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0020, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0, 1, 5, 0,  1, 0, 1, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  1, 0, 0, 16'h0080, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 16'h0080, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 0,  1, 1, 0, 16'h0080, 1, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0,  0, 0, 0, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 16'h0002, 1, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  1, 0, 0, 16'h0006, 2, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0,  1, 0, 0, 16'h000E, 3, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0,  1, 0, 0, 16'h001E, 4, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0,  0, 0, 0, 16'h001E, 4, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 1, 2, 0,  1, 0, 0, 16'h005A, 4, 0, 0));
    main_tbl.push_back(mk(1, 6, 1, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 16'h0058, 3, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0,  0, 0, 0, 16'h0050, 2, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0,  0, 0, 0, 16'h0040, 1, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0,  0, 0, 0, 16'h0000, 0, 0, 0));
    main_tbl.push_back(mk(1, 0, 0, 0, 0, 8, 1, 0, 0, 0,  1, 0, 0, 16'h0100, 1, 0, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0,  0, 0, 0, 16'h0100, 1, 1, 0));
    main_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0,  0, 0, 0, 16'h0000, 0, 1, 0));

    halt_tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 0, 0, 16'h0002, 1, 0, 0));
    halt_tbl.push_back(mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0,  1, 0, 0, 16'h0006, 2, 0, 0));
    halt_tbl.push_back(mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 1,  0, 0, 0, 16'h0006, 2, 0, 0));
    halt_tbl.push_back(mk(1, 4, 1, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 16'h0006, 2, 0, 0));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0,  0, 0, 0, 16'h0004, 1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0004, 1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0004, 1, 0, 0));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0,  0, 0, 0, 16'h0000, 0, 0, 1));
    halt_tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 1));
    halt_tbl.push_back(mk(1, 0, 1, 0, 1, 5, 1, 0, 0, 0,  0, 0, 0, 16'h0000, 0, 0, 1));

    apply_reset("reset0");
    for (int i = 0; i < main_tbl.size(); i++) do_row(main_tbl[i], "main", i);

    // Writeback to r0 is always an error and never touches the count.
    apply_reset("reset1");
    do_row(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 16'h0000, 0, 1, 0), "r0wb", 0);

    apply_reset("reset2");
    for (int i = 0; i < halt_tbl.size(); i++) do_row(halt_tbl[i], "halt", i);

    // Asynchronous reset while halted: hlt must drop before any clock edge.
    rst = 1'b1;
    #1;
    chk("async_rst.hlt", 0, hlt, 0);
    chk("async_rst.pend", 0, pend, 0);
    chk("async_rst.pend_cnt", 0, pend_cnt, 0);
    $display("async reset in HALT: hlt=%0b pend=%04h cnt=%0d", hlt, pend, pend_cnt);
    @(posedge clk);
    #1;
    rst = 1'b0;
    do_row(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0,  1, 0, 0, 16'h0200, 1, 0, 0), "post_rst", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
